// File: rtl/time_2.sv
// Calendar clock advancing one second per clk edge, with loadable fields and
// combinational rollover carries that look ahead to the next edge.
module time_2 (
  input  logic        clk,
  input  logic        time_set,
  input  logic        rst,
  input  logic [11:0] year_set,
  input  logic [3:0]  mon_set,
  input  logic [2:0]  week_set,
  input  logic [4:0]  day_set,
  input  logic [4:0]  hour_set,
  input  logic [5:0]  min_set,
  input  logic [5:0]  sec_set,
  output logic [11:0] year,
  output logic [3:0]  mon,
  output logic [2:0]  week,
  output logic [4:0]  day,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        year_carry,
  output logic        mon_carry,
  output logic        day_carry,
  output logic        hour_carry,
  output logic        min_carry
);

  logic       leap;
  logic [4:0] last_day;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic       day_wrap;
  logic       mon_wrap;
  logic       gate;

  always_comb begin
    leap = ((year % 12'd4) == 12'd0 && (year % 12'd100) != 12'd0) ||
           ((year % 12'd400) == 12'd0);
  end

  // Out-of-range months (possible after an unvalidated load) use 31 days.
  always_comb begin
    case (mon)
      4'd4, 4'd6, 4'd9, 4'd11: last_day = 5'd30;
      4'd2:                    last_day = leap ? 5'd29 : 5'd28;
      default:                 last_day = 5'd31;
    endcase
  end

  always_comb begin
    sec_wrap  = (sec >= 6'd59);
    min_wrap  = sec_wrap  && (min >= 6'd59);
    hour_wrap = min_wrap  && (hour >= 5'd23);
    day_wrap  = hour_wrap && (day >= last_day);
    mon_wrap  = day_wrap  && (mon >= 4'd12);
  end

  always_comb begin
    gate       = !rst && !time_set;
    min_carry  = gate && sec_wrap;
    hour_carry = gate && min_wrap;
    day_carry  = gate && hour_wrap;
    mon_carry  = gate && day_wrap;
    year_carry = gate && mon_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      year <= 12'd2000;
      mon  <= 4'd1;
      week <= 3'd6;
      day  <= 5'd1;
      hour <= 5'd0;
      min  <= 6'd0;
      sec  <= 6'd0;
    end else if (time_set) begin
      year <= year_set;
      mon  <= mon_set;
      week <= week_set;
      day  <= day_set;
      hour <= hour_set;
      min  <= min_set;
      sec  <= sec_set;
    end else begin
      sec <= sec_wrap ? 6'd0 : sec + 6'd1;
      if (sec_wrap)
        min <= (min >= 6'd59) ? 6'd0 : min + 6'd1;
      if (min_wrap)
        hour <= (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
      if (hour_wrap) begin
        week <= (week >= 3'd7) ? 3'd1 : week + 3'd1;
        day  <= (day >= last_day) ? 5'd1 : day + 5'd1;
      end
      if (day_wrap)
        mon <= (mon >= 4'd12) ? 4'd1 : mon + 4'd1;
      if (mon_wrap)
        year <= year + 12'd1;
    end
  end

endmodule

// File: tb/tb_time_2.sv
// Scoreboard bench for time_2: the driver queues expected snapshots tagged with
// a cycle number, the monitor compares them when that cycle is sampled.
module tb_time_2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        time_set = 1'b0;
  logic [11:0] year_set = '0;
  logic [3:0]  mon_set = '0;
  logic [2:0]  week_set = '0;
  logic [4:0]  day_set = '0;
  logic [4:0]  hour_set = '0;
  logic [5:0]  min_set = '0;
  logic [5:0]  sec_set = '0;
  logic [11:0] year;
  logic [3:0]  mon;
  logic [2:0]  week;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        year_carry, mon_carry, day_carry, hour_carry, min_carry;

  time_2 dut (
    .clk(clk), .time_set(time_set), .rst(rst),
    .year_set(year_set), .mon_set(mon_set), .week_set(week_set),
    .day_set(day_set), .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set),
    .year(year), .mon(mon), .week(week), .day(day), .hour(hour), .min(min), .sec(sec),
    .year_carry(year_carry), .mon_carry(mon_carry), .day_carry(day_carry),
    .hour_carry(hour_carry), .min_carry(min_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [45:0] vec;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // vector layout: year mon week day hour min sec {year,mon,day,hour,min}_carry
  function automatic logic [45:0] pack(input logic [11:0] y, input logic [3:0] m,
                                       input logic [2:0] w, input logic [4:0] d,
                                       input logic [4:0] h, input logic [5:0] mi,
                                       input logic [5:0] s, input logic [4:0] cy);
    return {y, m, w, d, h, mi, s, cy};
  endfunction

  task automatic expect_at(input int at, input string name, input logic [45:0] v);
    exp_t e;
    e.at = at; e.vec = v; e.name = name;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    logic [45:0] act;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      act = {year, mon, week, day, hour, min, sec,
             year_carry, mon_carry, day_carry, hour_carry, min_carry};
      while (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL %s: sample at cycle %0d was missed (now %0d)", e.name, e.at, cyc);
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        e = q.pop_front();
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL %s @%0d: got y=%0d m=%0d w=%0d d=%0d %0d:%0d:%0d cy=%b, want y=%0d m=%0d w=%0d d=%0d %0d:%0d:%0d cy=%b",
                   e.name, cyc,
                   act[45:34], act[33:30], act[29:27], act[26:22], act[21:17], act[16:11], act[10:5], act[4:0],
                   e.vec[45:34], e.vec[33:30], e.vec[29:27], e.vec[26:22], e.vec[21:17], e.vec[16:11], e.vec[10:5], e.vec[4:0]);
        end
      end
    end
  end

  task automatic load(input logic [11:0] y, input logic [3:0] m, input logic [2:0] w,
                      input logic [4:0] d, input logic [4:0] h, input logic [5:0] mi,
                      input logic [5:0] s, output int at);
    time_set = 1'b1;
    year_set = y; mon_set = m; week_set = w; day_set = d;
    hour_set = h; min_set = mi; sec_set = s;
    @(negedge clk);
    time_set = 1'b0;
    at = cyc;
  endtask

  // Load y-m-d 23:59:00 week w, then expect the date ny-nm-nd week nw 60 clocks later.
  task automatic run_case(input string name,
                          input logic [11:0] y, input logic [3:0] m, input logic [4:0] d, input logic [2:0] w,
                          input logic [11:0] ny, input logic [3:0] nm, input logic [4:0] nd, input logic [2:0] nw,
                          input logic [4:0] cy59);
    int l;
    load(y, m, w, d, 5'd23, 6'd59, 6'd0, l);
    expect_at(l,      {name, "_load"}, pack(y, m, w, d, 5'd23, 6'd59, 6'd0,  5'b00000));
    expect_at(l + 58, {name, "_c58"},  pack(y, m, w, d, 5'd23, 6'd59, 6'd58, 5'b00000));
    expect_at(l + 59, {name, "_c59"},  pack(y, m, w, d, 5'd23, 6'd59, 6'd59, cy59));
    expect_at(l + 60, {name, "_c60"},  pack(ny, nm, nw, nd, 5'd0, 6'd0, 6'd0, 5'b00000));
    repeat (61) @(negedge clk);
  endtask

  // Driver
  initial begin
    int l;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    expect_at(cyc, "reset_hold", pack(12'd2000, 4'd1, 3'd6, 5'd1, 5'd0, 6'd0, 6'd0, 5'b00000));
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc, "reset_release", pack(12'd2000, 4'd1, 3'd6, 5'd1, 5'd0, 6'd0, 6'd0, 5'b00000));
    @(negedge clk);
    expect_at(cyc, "first_count", pack(12'd2000, 4'd1, 3'd6, 5'd1, 5'd0, 6'd0, 6'd1, 5'b00000));
    @(negedge clk);

    run_case("leap2000",   12'd2000, 4'd2,  5'd28, 3'd1, 12'd2000, 4'd2, 5'd29, 3'd2, 5'b00111);
    run_case("cent2100",   12'd2100, 4'd2,  5'd28, 3'd6, 12'd2100, 4'd3, 5'd1,  3'd7, 5'b01111);
    run_case("leap1996",   12'd1996, 4'd2,  5'd28, 3'd3, 12'd1996, 4'd2, 5'd29, 3'd4, 5'b00111);
    run_case("leap2004",   12'd2004, 4'd2,  5'd28, 3'd6, 12'd2004, 4'd2, 5'd29, 3'd7, 5'b00111);
    run_case("feb2015",    12'd2015, 4'd2,  5'd28, 3'd6, 12'd2015, 4'd3, 5'd1,  3'd7, 5'b01111);
    run_case("newyear",    12'd2015, 4'd12, 5'd31, 3'd4, 12'd2016, 4'd1, 5'd1,  3'd5, 5'b11111);
    run_case("apr30",      12'd2015, 4'd4,  5'd30, 3'd4, 12'd2015, 4'd5, 5'd1,  3'd5, 5'b01111);
    run_case("mar30",      12'd2015, 4'd3,  5'd30, 3'd1, 12'd2015, 4'd3, 5'd31, 3'd2, 5'b00111);
    run_case("mar29_wk7",  12'd2015, 4'd3,  5'd29, 3'd7, 12'd2015, 4'd3, 5'd30, 3'd1, 5'b00111);
    run_case("year4095",   12'd4095, 4'd12, 5'd31, 3'd1, 12'd0,    4'd1, 5'd1,  3'd2, 5'b11111);

    // rst together with time_set mid-count: carries gated, reset wins
    load(12'd2015, 4'd12, 3'd4, 5'd31, 5'd23, 6'd59, 6'd58, l);
    @(negedge clk);
    rst = 1'b1; time_set = 1'b1;
    year_set = 12'd1234; mon_set = 4'd5; week_set = 3'd2; day_set = 5'd9;
    hour_set = 5'd7; min_set = 6'd8; sec_set = 6'd9;
    expect_at(cyc, "rst_set_gate", pack(12'd2015, 4'd12, 3'd4, 5'd31, 5'd23, 6'd59, 6'd59, 5'b00000));
    @(negedge clk);
    rst = 1'b0; time_set = 1'b0;
    expect_at(cyc, "rst_set_result", pack(12'd2000, 4'd1, 3'd6, 5'd1, 5'd0, 6'd0, 6'd0, 5'b00000));
    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #100000;
    join_any
    if (!done) begin
      errors++;
      $display("FAIL watchdog: driver did not complete within time budget");
    end
    #2;
    if (q.size() != 0) begin
      errors += q.size();
      checks += q.size();
      $display("FAIL scoreboard_drain: %0d expected samples never compared, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_2.md
TIME_2 -- requirements
Module: time_2

Interface
REQ-001 SHALL expose clk  input  1  system clock, one rising edge = one second.
REQ-002 SHALL expose rst  input  1  synchronous active-high clear.
REQ-003 SHALL expose time_set  input  1  synchronous load enable for all *_set inputs.
REQ-004 SHALL expose year_set  input  12  year to load, binary.
REQ-005 SHALL expose mon_set  input  4  month to load, 1-12.
REQ-006 SHALL expose week_set  input  3  weekday to load, 1=Mon ... 7=Sun.
REQ-007 SHALL expose day_set  input  5  day of month to load, 1-31.
REQ-008 SHALL expose hour_set  input  5  hour to load, 0-23.
REQ-009 SHALL expose min_set  input  6  minute to load, 0-59.
REQ-010 SHALL expose sec_set  input  6  second to load, 0-59.
REQ-011 SHALL expose year, mon, week, day, hour, min, sec  outputs  12/4/3/5/5/6/6  current registered calendar/time.
REQ-012 SHALL expose year_carry, mon_carry, day_carry, hour_carry, min_carry  outputs  1 each  rollover indicators.
REQ-013 Port order SHALL be: clk, time_set, rst, year_set, mon_set, week_set, day_set, hour_set, min_set, sec_set, year, mon, week, day, hour, min, sec, year_carry, mon_carry, day_carry, hour_carry, min_carry.
REQ-014 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-015 Priority per rising edge SHALL be: rst, then time_set, then normal counting.
REQ-016 time_set=1 SHALL load every field from its *_set input on that edge, unvalidated; counting resumes on the next edge.
REQ-017 Normal counting SHALL increment sec each edge; sec>=59 wraps to 0 and increments min.
REQ-018 min>=59 at a minute rollover SHALL wrap to 0 and increment hour; hour>=23 at an hour rollover SHALL wrap to 0 and trigger a day rollover.
REQ-019 Day rollover SHALL advance week (7 wraps to 1) and, if day>=last day of month, set day=1 and increment mon; otherwise day+1.
REQ-020 Last day SHALL be 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for 2 in a leap year, else 28.
REQ-021 Leap year SHALL be (year mod 4 == 0 and year mod 100 != 0) or year mod 400 == 0.
REQ-022 mon>=12 at month rollover SHALL wrap to 1 and increment year; year 4095 wraps to 0.
REQ-023 Carries SHALL be combinational from current state, low when rst or time_set is 1: min_carry = sec>=59; hour_carry = min_carry and min>=59; day_carry = hour_carry and hour>=23; mon_carry = day_carry and day>=last day; year_carry = mon_carry and mon>=12.
REQ-024 Carries SHALL be high exactly in the cycle before the edge performing the corresponding rollover.
REQ-025 Month lengths SHALL use the current year/mon register values (before increment).

Reset
REQ-026 rst=1 at an edge SHALL set year=2000, mon=1, day=1, week=6, hour=0, min=0, sec=0, overriding time_set.
REQ-027 All carries SHALL be 0 while rst=1 and in the cycle after reset release (sec=0).

Verification
REQ-028 Load 2000-02-28 23:59:00 week 1, run 60 clocks -> 2000-02-29 00:00:00 week 2; day_carry high at clock 59, mon_carry low.
REQ-029 Load 2100-02-28 23:59:00 week 6, run 60 clocks -> 2100-03-01 00:00:00 week 7; mon_carry high at clock 59 (non-leap century).
REQ-030 Load 1996-02-28 and 2004-02-28 23:59:00, run 60 clocks -> 02-29 in both; 2015-02-28 -> 2015-03-01.
REQ-031 Load 2015-12-31 23:59:00 week 4, run 60 clocks -> 2016-01-01 00:00:00 week 5; all five carries high at clock 59 only.
REQ-032 Load 2015-04-30 and 2015-03-30 23:59:00 -> after 60 clocks 05-01 and 03-31 respectively; 2015-03-29 week 7 -> week 1.
REQ-033 Assert rst and time_set together mid-count -> next state 2000-01-01 00:00:00 week 6, carries 0.
